// File: rtl/data_memory_ram_pkg.sv
// Shared constants for the MEM-stage data RAM: datapath width, word size and default depth.
package data_memory_ram_pkg;
    localparam int XLEN                   = 32;
    localparam int WORD_BYTES             = 4;
    localparam int DEFAULT_DATA_MEM_DEPTH = 256;

    // Low address bits that select a byte within a word and are therefore ignored.
    localparam int BYTE_OFFSET_BITS = $clog2(WORD_BYTES);
endpackage : data_memory_ram_pkg

// File: rtl/data_memory_ram_array.sv
// Storage array for the data RAM.
// Provides an asynchronous whole-array clear, one synchronous write port and one combinational read port.
module data_memory_ram_array
    import data_memory_ram_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DATA_MEM_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            write_en,
    input  logic [AW-1:0]   write_idx,
    input  logic [XLEN-1:0] write_data,
    input  logic [AW-1:0]   read_idx,
    output logic [XLEN-1:0] read_word
);

    // Power-up contents match the post-reset state.
    logic [XLEN-1:0] mem [DEPTH] = '{default: '0};

    // Reset must clear every word with no clock, so the array is register-based.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write_en) begin
            mem[write_idx] <= write_data;
        end
    end

    assign read_word = mem[read_idx];

endmodule : data_memory_ram_array

// File: rtl/data_memory_ram.sv
// Word-organised data RAM for the single-cycle RISC-V datapath.
// Performs address decode and range check, and gates the combinational read so a load completes in the same cycle.
module data_memory_ram
    import data_memory_ram_pkg::*;
#(
    parameter int DATA_MEM_DEPTH = DEFAULT_DATA_MEM_DEPTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_read_en,
    input  logic            mem_write_en,
    input  logic [XLEN-1:0] address,
    input  logic [XLEN-1:0] write_data,
    output logic [XLEN-1:0] read_data
);

    localparam int AW = $clog2(DATA_MEM_DEPTH);

    logic [AW-1:0]   word_idx;
    logic            in_range;
    logic [XLEN-1:0] array_word;

    // Misaligned addresses fall into the containing word.
    assign word_idx = address[AW+BYTE_OFFSET_BITS-1:BYTE_OFFSET_BITS];
    // Any set bit above the array's span is out of range; there is no aliasing.
    assign in_range = (address >> (AW + BYTE_OFFSET_BITS)) == '0;

    data_memory_ram_array #(
        .DEPTH (DATA_MEM_DEPTH),
        .AW    (AW)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .write_en   (mem_write_en && in_range),
        .write_idx  (word_idx),
        .write_data (write_data),
        .read_idx   (word_idx),
        .read_word  (array_word)
    );

    // No write-through: a same-cycle read sees the old word until the edge.
    assign read_data = (mem_read_en && in_range && rst_n) ? array_word : '0;

endmodule : data_memory_ram

// File: tb/tb_data_memory_ram.sv
// Self-checking bench for data_memory_ram: directed scenarios followed by random traffic against a word-array model.
module tb_data_memory_ram;

    localparam int DEPTH      = 256;
    localparam int BYTE_SPAN  = DEPTH * 4;

    logic        clk;
    logic        rst_n;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    int checks   = 0;
    int failures = 0;

    // Reference model: one 32-bit entry per word, indexed by byte address / 4.
    logic [31:0] model [DEPTH];

    data_memory_ram #(
        .DATA_MEM_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .address      (address),
        .write_data   (write_data),
        .read_data    (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic re, input logic [31:0] addr, input logic rstn);
        if (!re || !rstn || addr >= BYTE_SPAN)
            return 32'h0;
        return model[addr / 4];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    task automatic model_write(input logic we, input logic [31:0] addr, input logic [31:0] data);
        if (we && addr < BYTE_SPAN)
            model[addr / 4] = data;
    endtask

    task automatic check(input string tag, input logic [31:0] expected);
        checks++;
        assert (read_data === expected)
        else begin
            failures++;
            $error("FAIL %s addr=%h re=%0b observed=%h expected=%h", tag, address, mem_read_en, read_data, expected);
        end
        $display("txn %-14s addr=%h re=%0b we=%0b rd=%h exp=%h", tag, address, mem_read_en, mem_write_en, read_data, expected);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        mem_read_en  = 1'b0;
        mem_write_en = 1'b1;
        address      = addr;
        write_data   = data;
        @(posedge clk);
        #1;
        mem_write_en = 1'b0;
        model_write(1'b1, addr, data);
    endtask

    task automatic do_read(input string tag, input logic re, input logic [31:0] addr);
        mem_read_en  = re;
        mem_write_en = 1'b0;
        address      = addr;
        #1;
        check(tag, model_read(re, addr, rst_n));
    endtask

    initial begin
        logic        re, we;
        logic [31:0] addr, data;

        model_clear();
        rst_n        = 1'b0;
        mem_read_en  = 1'b1;
        mem_write_en = 1'b0;
        address      = 32'h4;
        write_data   = 32'h0;
        #12;
        check("reset_read", 32'h0);
        rst_n = 1'b1;

        // 1. post-reset read
        @(negedge clk);
        do_read("post_reset", 1'b1, 32'h4);
        check("post_rst_abs", 32'h0);

        // 2. store then load
        do_write(32'h4, 32'hDEAD_BEEF);
        do_read("load_04", 1'b1, 32'h4);
        check("load_04_abs", 32'hDEAD_BEEF);

        // 3. unwritten word and misaligned access
        do_read("unwritten_08", 1'b1, 32'h8);
        do_read("misalign_06", 1'b1, 32'h6);
        check("misalign_abs", 32'hDEAD_BEEF);

        // 4. read disabled, then out-of-range store
        do_read("read_dis", 1'b0, 32'h4);
        check("read_dis_abs", 32'h0);
        do_write(32'h400, 32'h1234_5678);
        do_read("oor_400", 1'b1, 32'h400);
        check("oor_400_abs", 32'h0);
        do_read("word0_intact", 1'b1, 32'h0);
        check("word0_abs", 32'h0);
        do_read("last_word", 1'b1, BYTE_SPAN - 4);

        // 5. same-cycle read+write: old data before the edge, new after
        @(negedge clk);
        mem_read_en  = 1'b1;
        mem_write_en = 1'b1;
        address      = 32'h4;
        write_data   = 32'h1111_1111;
        #1;
        check("rw_before", 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        model_write(1'b1, 32'h4, 32'h1111_1111);
        check("rw_after", 32'h1111_1111);
        mem_write_en = 1'b0;

        // 6. asynchronous reset pulse between edges clears with no clock
        #1;
        rst_n = 1'b0;
        #1;
        check("in_reset", 32'h0);
        rst_n = 1'b1;
        model_clear();
        #1;
        check("after_async", 32'h0);
        mem_read_en = 1'b1;

        // writes ignored while held in reset
        @(negedge clk);
        rst_n        = 1'b0;
        mem_write_en = 1'b1;
        address      = 32'h10;
        write_data   = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        mem_write_en = 1'b0;
        rst_n        = 1'b1;
        do_read("write_in_rst", 1'b1, 32'h10);
        check("wir_abs", 32'h0);

        // Random traffic, mostly in range with occasional far addresses.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            re   = 1'($urandom_range(0, 3) != 0);
            we   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, BYTE_SPAN + 15));
            data = $urandom;
            mem_read_en  = re;
            mem_write_en = we;
            address      = addr;
            write_data   = data;
            #1;
            check("rand_pre", model_read(re, addr, 1'b1));
            @(posedge clk);
            #1;
            model_write(we, addr, data);
            check("rand_post", model_read(re, addr, 1'b1));
            mem_write_en = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Bound the run regardless of what the stimulus does.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_data_memory_ram
